// File: rtl/bcd8_to_binary.sv
// bcd8_to_binary: 3-digit BCD (0..299) to 8-bit binary via reverse double-dabble, START/BUSY/DONE handshake.
// Optional digit validation is enabled with `define BCD_DIGIT_CHECK_EN.
module bcd8_to_binary #(
  parameter bit OVF_SAT = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic [7:0] A,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVF,
  output logic       ERR
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t      state_q, state_d;
  logic [9:0]  bcd_q, bcd_d;
  logic [8:0]  bin_q, bin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic        done_q, done_d, ovf_q, ovf_d, err_q, err_d;
  logic [18:0] sh;
  logic [3:0]  tens_c, ones_c;
  logic        bad_q;
`ifdef BCD_DIGIT_CHECK_EN
  logic bad_d;
  assign bad_d = (state_q == IDLE && START) ? (TENS > 4'd9 || ONES > 4'd9 || &HUNDREDS) : bad_q;
  always_ff @(posedge CLK)
    bad_q <= RST ? 1'b0 : bad_d;
`else
  assign bad_q = 1'b0;
`endif
  always_comb begin
    sh      = {bcd_q, bin_q} >> 1;
    tens_c  = sh[16:13] >= 4'd8 ? sh[16:13] - 4'd3 : sh[16:13];
    ones_c  = sh[12:9] >= 4'd8 ? sh[12:9] - 4'd3 : sh[12:9];
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        bcd_d   = {HUNDREDS, TENS, ONES};
        bin_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d   = {sh[18:17], tens_c, ones_c};
        bin_d   = sh[8:0];
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'd8 ? FIN : SHIFT;
      end
      FIN: begin
        err_d   = bad_q;
        ovf_d   = !bad_q && bin_q[8];
        a_d     = bad_q ? 8'h00 : (bin_q[8] && OVF_SAT) ? 8'hFF : bin_q[7:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
  assign A    = a_q;
  assign BUSY = state_q != IDLE;
  assign DONE = done_q;
  assign OVF  = ovf_q;
  assign ERR  = err_q;
endmodule

// File: doc/bcd8_to_binary.md
Name: bcd8_to_binary

Overview:
- Sequential inverse of the team's 8-bit binary-to-BCD converter.
- Takes a 3-digit BCD value (HUNDREDS 2 bits, TENS and ONES 4 bits each, range 0..299) and produces the 8-bit binary equivalent.
- Uses reverse double-dabble: shift right one bit per clock, then subtract 3 from any digit >= 8.
- Sits between keypad/BCD entry logic and binary datapaths; uses a START/BUSY/DONE handshake.

Parameters:
- OVF_SAT, default 1: behaviour when the result exceeds 255. 1 = saturate A to 255; 0 = wrap A to result mod 256. OVF is reported in both cases.

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  request conversion; sampled only in IDLE
- HUNDREDS  input  2  BCD hundreds digit (0..2 valid)
- TENS  input  4  BCD tens digit
- ONES  input  4  BCD ones digit
- A  output  8  binary result; registered; held until next DONE
- BUSY  output  1  high while a conversion is in progress
- DONE  output  1  one-cycle pulse when A/OVF/ERR are updated
- OVF  output  1  result > 255; valid with DONE, held until next DONE
- ERR  output  1  invalid digit; see Optional Feature; held until next DONE

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset values: A=0, BUSY=0, DONE=0, OVF=0, ERR=0. State goes to IDLE, iteration counter to 0, shift register cleared.
- RST asserted mid-conversion aborts it:
  - no DONE pulse;
  - A, OVF and ERR return to 0;
  - the next cycle after RST deasserts is IDLE.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - If START=1 on an edge, capture {HUNDREDS, TENS, ONES} into a 10-bit BCD register.
  - Clear the 9-bit binary accumulator and the counter; go to SHIFT.
  - START=0: stay in IDLE.
- SHIFT, one iteration per cycle:
  - Shift the 19-bit concatenation {BCD, binary} right by 1; the BCD LSB enters the binary MSB.
  - Then, for the TENS and ONES fields, if the field is >= 8, subtract 3.
  - HUNDREDS never needs correction.
  - Counter increments each iteration; after the 9th iteration go to FIN.
- FIN:
  - Register A, OVF and ERR from the 9-bit result r.
  - OVF = r[8].
  - A = r[7:0] if OVF=0. If OVF=1: A = 8'hFF when OVF_SAT=1, A = r[7:0] when OVF_SAT=0.
  - DONE=1 for this cycle only; then go to IDLE.
- BUSY: 1 in SHIFT and FIN, 0 in IDLE.
- Latency: START sampled at edge k → DONE high during the cycle following edge k+10, i.e. 10 cycles of BUSY.
- Input capture: inputs are sampled only at the START edge. Changes to HUNDREDS/TENS/ONES during BUSY have no effect.
- START handling:
  - START while BUSY (including the FIN cycle) is ignored, not queued.
  - START held continuously gives back-to-back conversions with one IDLE cycle between DONE and the next BUSY.
- Boundary values:
  - 0/0/0 → A=0.
  - 2/5/5 → A=255, OVF=0.
  - 2/5/6..2/9/9 → OVF=1.
  - HUNDREDS=3 is treated as an invalid digit (see Optional Feature).

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - At the START edge, if TENS>9, ONES>9 or HUNDREDS=3, the conversion still runs for full latency.
  - In FIN: ERR=1, A=0, OVF=0.
  - Otherwise ERR=0.
- Not defined:
  - ERR is constant 0 and no check logic is synthesized.
  - Invalid digits are converted by the same algorithm; the result is deterministic but unspecified.

Test Plan:
- Hold RST 2 cycles with START=1 → A=0, BUSY=0, DONE=0, OVF=0, ERR=0 throughout reset. First conversion starts on the first edge after RST deasserts.
- HUNDREDS=2, TENS=5, ONES=5, START pulse at edge k → BUSY high for 10 cycles; DONE single pulse after edge k+10; A=8'hFF, OVF=0. A stays 8'hFF after DONE.
- Convert 0/0/0, 0/9/9, 1/2/8, 0/0/1 → A = 8'h00, 8'h63, 8'h80, 8'h01, each with OVF=0. Inputs are changed to 2/9/9 three cycles after each START, and results are unaffected.
- 2/9/9 → OVF=1 with A=8'hFF when OVF_SAT=1; OVF=1 with A=8'h2B (43) when OVF_SAT=0. 2/5/6 → OVF=1; A=8'h00 when OVF_SAT=0.
- START pulsed again at BUSY cycle 5 and in the FIN cycle → ignored, exactly one DONE. START held high → DONE pulses every 11 cycles. RST at iteration 4 → no DONE; A=0 next cycle.
- BCD_DIGIT_CHECK_EN defined, TENS=4'hA → DONE after 10 cycles with ERR=1, A=0, OVF=0. Next valid 0/4/2 → ERR=0, A=8'h2A.
